// File: rtl/id_reg_bank.sv
// Read-only ID word bank at BASE_ADDR with decode errors; IDREG_ACCESS_CNT_EN adds an access counter after the last ID.
// Latency: request to rsp_valid in 2 edges; one transaction in flight, req_ready low until the response handshake.
module id_reg_bank #(
  parameter int                        ADDR_W     = 32,
  parameter int                        DATA_W     = 32,
  parameter int                        NUM_IDS    = 3,
  parameter logic [ADDR_W-1:0]         BASE_ADDR  = 32'h0010_0000,
  parameter logic [NUM_IDS*DATA_W-1:0] ID_VALUES  = {32'd11266558, 32'd13199173, 32'd11685268},
  parameter bit                        SWAP_BYTES = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int              BYTES     = DATA_W / 8;
  localparam int              SH        = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam logic [ADDR_W:0] WIN_END   = (ADDR_W+1)'(NUM_IDS * BYTES);
  localparam logic [ADDR_W:0] LANE_MASK = (ADDR_W+1)'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   off, word_idx;
  logic              borrow, id_hit;
  logic [DATA_W-1:0] id_word, id_out, lk_data;
  logic              lk_err;

  // The extra top bit of off catches addresses below the base as a borrow.
  always_comb begin
    off      = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    borrow   = off[ADDR_W];
    id_hit   = !borrow && (off < WIN_END) && ((off & LANE_MASK) == '0);
    word_idx = off >> SH;
    id_word  = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      if (word_idx == (ADDR_W+1)'(i)) id_word = ID_VALUES[i*DATA_W +: DATA_W];
    end
    id_out = id_word;
    if (SWAP_BYTES) begin
      for (int b = 0; b < BYTES; b++) id_out[b*8 +: 8] = id_word[(BYTES-1-b)*8 +: 8];
    end
  end

`ifdef IDREG_ACCESS_CNT_EN
  logic [DATA_W-1:0] acc_cnt;
  logic              cnt_hit, id_rd_q;

  assign cnt_hit = !borrow && (off == WIN_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
      id_rd_q <= 1'b0;
    end else begin
      if (state == LOOKUP) id_rd_q <= id_hit;
      if (rsp_valid && rsp_ready && id_rd_q && (acc_cnt != '1)) acc_cnt <= acc_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    lk_data = id_hit ? id_out : '0;
    lk_err  = !id_hit;
`ifdef IDREG_ACCESS_CNT_EN
    if (cnt_hit) begin
      lk_data = acc_cnt;
      lk_err  = 1'b0;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_valid && req_ready) addr_q <= req_addr;
      if (state == LOOKUP) begin
        rsp_data <= lk_data;
        rsp_err  <= lk_err;
      end
    end
  end

endmodule

// File: tb/tb_id_reg_bank.sv
// Bench for id_reg_bank: swapped and unswapped instances driven in parallel against a reference model.
module tb_id_reg_bank;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic        rq_a, rq_b, rv_a, rv_b, er_a, er_b;
  logic [31:0] d_a, d_b;

  int          total = 0;
  int          bad = 0;
  logic [31:0] cnt_m = '0;
  logic [31:0] ids [3] = '{32'd11685268, 32'd13199173, 32'd11266558};

  always #5 clk = ~clk;

  id_reg_bank u_swap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rq_a), .req_addr(req_addr),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_data(d_a), .rsp_err(er_a)
  );

  id_reg_bank #(.SWAP_BYTES(1'b0)) u_noswap (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rq_b), .req_addr(req_addr),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_data(d_b), .rsp_err(er_b)
  );

  function automatic longint offset_of(input logic [31:0] a);
    return longint'({32'b0, a}) - longint'({32'b0, BASE});
  endfunction

  function automatic bit is_id(input logic [31:0] a);
    longint off = offset_of(a);
    return (off >= 0) && (off < 12) && (off % 4 == 0);
  endfunction

  // Returns {err, data} for a read of address a.
  function automatic logic [32:0] model_rsp(input logic [31:0] a, input bit swap);
    longint off = offset_of(a);
    logic [31:0] w;
    if (is_id(a)) begin
      w = ids[int'(off / 4)];
      if (swap) w = {w[7:0], w[15:8], w[23:16], w[31:24]};
      return {1'b0, w};
    end
`ifdef IDREG_ACCESS_CNT_EN
    if (off == 12) return {1'b0, cnt_m};
`endif
    return {1'b1, 32'h0};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt_m = '0;
  endtask

  // Runs one read; rsp_ready held low for hold cycles after rsp_valid rises.
  task automatic xact(input logic [31:0] a, input int hold,
                      output logic [31:0] da, output logic [31:0] db,
                      output logic ea, output logic eb, output int lat,
                      output bit stable, output bit busy_ok, output bit done_ok);
    stable = 1'b1; busy_ok = 1'b1; lat = 0;
    req_addr = a; req_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      req_valid = 1'b0; req_addr = $urandom;
      if (!rv_a && (rq_a || rq_b)) busy_ok = 1'b0;
    end while (!rv_a && lat < 20);
    da = d_a; db = d_b; ea = er_a; eb = er_b;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom;
      @(posedge clk); #1;
      if (!rv_a || !rv_b || d_a !== da || d_b !== db || er_a !== ea || er_b !== eb) stable = 1'b0;
      if (rq_a || rq_b) busy_ok = 1'b0;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    done_ok = !rv_a && !rv_b && rq_a && rq_b;
    if (is_id(a)) cnt_m = cnt_m + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rq_a !== 1'b0 || rq_b !== 1'b0) begin bad++; $display("FAIL reset_req_ready got %b/%b want 0", rq_a, rq_b); end
    total++; if (rv_a !== 1'b0 || rv_b !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b/%b want 0", rv_a, rv_b); end
    total++; if (d_a !== 32'h0 || er_a !== 1'b0) begin bad++; $display("FAIL reset_rsp got data=%h err=%b want 0/0", d_a, er_a); end
    rst_n = 1'b1;
    cnt_m = '0;
    #1;
    total++; if (rq_a !== 1'b1 || rq_b !== 1'b1) begin bad++; $display("FAIL release_req_ready got %b/%b want 1", rq_a, rq_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] da, db; logic ea, eb; int lat; bit st, bz, dn;
    xact(BASE, 0, da, db, ea, eb, lat, st, bz, dn);
    total++; if (lat != 2) begin bad++; $display("FAIL basic_latency got %0d want 2", lat); end
    total++; if (da !== 32'h944db200 || ea !== 1'b0) begin bad++; $display("FAIL basic_swap got %h/%b want 944db200/0", da, ea); end
    total++; if (db !== 32'h00b24d94 || eb !== 1'b0) begin bad++; $display("FAIL basic_noswap got %h/%b want 00b24d94/0", db, eb); end
    total++; if (!dn) begin bad++; $display("FAIL basic_return_idle got 0 want 1"); end
  endtask

  task automatic test_hold();
    logic [31:0] da, db; logic ea, eb; int lat; bit st, bz, dn;
    xact(BASE + 32'h8, 5, da, db, ea, eb, lat, st, bz, dn);
    total++; if (da !== 32'hfee9ab00 || ea !== 1'b0) begin bad++; $display("FAIL hold_data got %h/%b want fee9ab00/0", da, ea); end
    total++; if (db !== 32'h00abe9fe) begin bad++; $display("FAIL hold_noswap got %h want 00abe9fe", db); end
    total++; if (!st) begin bad++; $display("FAIL hold_stable got 0 want 1"); end
    total++; if (!bz) begin bad++; $display("FAIL hold_req_ready_low got 0 want 1"); end
    total++; if (!dn) begin bad++; $display("FAIL hold_return_idle got 0 want 1"); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3] = '{BASE + 32'h2, 32'h000F_FFFC, 32'hFFFF_FFFC};
    logic [31:0] da, db; logic ea, eb; int lat; bit st, bz, dn;
    foreach (addrs[i]) begin
      xact(addrs[i], 1, da, db, ea, eb, lat, st, bz, dn);
      total++;
      if (ea !== 1'b1 || eb !== 1'b1 || da !== 32'h0 || db !== 32'h0) begin
        bad++; $display("FAIL err_addr_%h got %h/%b %h/%b want 0/1", addrs[i], da, ea, db, eb);
      end
    end
  endtask

  task automatic test_counter();
    logic [31:0] da, db; logic ea, eb; int lat; bit st, bz, dn;
    logic [31:0] exp_d; logic exp_e;
    logic [31:0] seq [4] = '{BASE, BASE + 32'h4, BASE + 32'h2, BASE + 32'h8};
    do_reset();
    foreach (seq[i]) xact(seq[i], 0, da, db, ea, eb, lat, st, bz, dn);
`ifdef IDREG_ACCESS_CNT_EN
    exp_d = 32'd3; exp_e = 1'b0;
`else
    exp_d = 32'd0; exp_e = 1'b1;
`endif
    xact(BASE + 32'hC, 0, da, db, ea, eb, lat, st, bz, dn);
    total++; if (da !== exp_d || ea !== exp_e) begin bad++; $display("FAIL counter_word got %h/%b want %h/%b", da, ea, exp_d, exp_e); end
    total++; if (db !== exp_d || eb !== exp_e) begin bad++; $display("FAIL counter_noswap got %h/%b want %h/%b", db, eb, exp_d, exp_e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] da, db; logic ea, eb; int lat; bit st, bz, dn; bit stale;
    req_addr = BASE + 32'h8; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0; #1;
    total++; if (rv_a !== 1'b0 || rq_a !== 1'b0) begin bad++; $display("FAIL rst_lookup got valid=%b ready=%b want 0/0", rv_a, rq_a); end
    #2 rst_n = 1'b1; cnt_m = '0;
    stale = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (rv_a || rv_b) stale = 1'b1; end
    total++; if (stale) begin bad++; $display("FAIL rst_lookup_stale got 1 want 0"); end
    req_addr = BASE + 32'h8; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (rv_a !== 1'b1) begin bad++; $display("FAIL rst_resp_setup got %b want 1", rv_a); end
    rst_n = 1'b0; #1;
    total++; if (rv_a !== 1'b0 || d_a !== 32'h0 || er_a !== 1'b0) begin bad++; $display("FAIL rst_resp got %b/%h/%b want 0/0/0", rv_a, d_a, er_a); end
    #2 rst_n = 1'b1; cnt_m = '0;
    stale = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (rv_a || rv_b) stale = 1'b1; end
    total++; if (stale) begin bad++; $display("FAIL rst_resp_stale got 1 want 0"); end
    xact(BASE + 32'h4, 0, da, db, ea, eb, lat, st, bz, dn);
    total++; if (da !== 32'h4567c900 || ea !== 1'b0) begin bad++; $display("FAIL rst_after_read got %h/%b want 4567c900/0", da, ea); end
  endtask

  task automatic test_random();
    logic [31:0] a, da, db; logic ea, eb; int lat; bit st, bz, dn;
    logic [32:0] ea_m, eb_m;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: a = BASE + 32'($urandom_range(0, 15));
        1: a = BASE - 32'($urandom_range(1, 8));
        2: a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: a = $urandom;
      endcase
      ea_m = model_rsp(a, 1'b1);
      eb_m = model_rsp(a, 1'b0);
      xact(a, $urandom_range(0, 3), da, db, ea, eb, lat, st, bz, dn);
      total++;
      if ({ea, da} !== ea_m || {eb, db} !== eb_m || lat != 2 || !st || !bz || !dn) begin
        bad++;
        $display("FAIL rand_%h got %b/%h %b/%h lat=%0d st=%b bz=%b dn=%b want %b/%h %b/%h lat=2 flags=1",
                 a, ea, da, eb, db, lat, st, bz, dn, ea_m[32], ea_m[31:0], eb_m[32], eb_m[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_errors();
    test_counter();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
